// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch queue: default widths, the exception
// field layout and a lane-mask population count.
package fetch_pkg;

  localparam int unsigned FQ_DATA_W = 64;
  localparam int unsigned FQ_EXCP_W = 5;

  typedef struct packed {
    logic [3:0] num;
    logic       valid;
  } excp_t;

  function automatic int unsigned popcnt(input logic [31:0] mask);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (mask[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/fq_regfile.sv
// Fetch queue storage: DEPTH entries, WR_P write ports, RD_P asynchronous read
// ports. No reset; contents are only meaningful between head and tail.
module fq_regfile #(
  parameter int unsigned WIDTH = 69,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WR_P  = 2,
  parameter int unsigned RD_P  = 2,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [WR_P-1:0]       wr_en,
  input  logic [WR_P*IW-1:0]    wr_idx,
  input  logic [WR_P*WIDTH-1:0] wr_data,
  input  logic [RD_P*IW-1:0]    rd_idx,
  output logic [RD_P*WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < WR_P; p++) begin
      if (wr_en[p]) mem[wr_idx[p*IW +: IW]] <= wr_data[p*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned q = 0; q < RD_P; q++) begin
      rd_data[q*WIDTH +: WIDTH] = mem[rd_idx[q*IW +: IW]];
    end
  end

endmodule

// File: rtl/fetch_queue_mp.sv
// Multi-lane in-order fetch queue between fetch and decode. Exception entries
// issue alone on lane 0; flush empties the queue in one cycle.
module fetch_queue_mp
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W    = FQ_DATA_W,
  parameter int unsigned EXCP_W    = FQ_EXCP_W,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ENQ_W     = 2,
  parameter int unsigned DEQ_W     = 2,
  parameter int unsigned AF_THRESH = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [ENQ_W-1:0]           enq_valid,
  input  logic [ENQ_W*DATA_W-1:0]    enq_data,
  input  logic [ENQ_W*EXCP_W-1:0]    enq_excp,
  output logic                       enq_ready,
  output logic [DEQ_W-1:0]           deq_valid,
  output logic [DEQ_W*DATA_W-1:0]    deq_data,
  output logic [DEQ_W*EXCP_W-1:0]    deq_excp,
  input  logic [DEQ_W-1:0]           deq_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned EW = DATA_W + EXCP_W;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ENQ_P   = PW'(ENQ_W);
  localparam logic [PW-1:0] AF_P    = PW'(AF_THRESH);

  logic [PW-1:0] head, tail;
  logic [PW-1:0] n_enq, n_deq, count_next;
  logic          enq_fire;

  logic [ENQ_W-1:0]    wr_en;
  logic [ENQ_W*IW-1:0] wr_idx;
  logic [ENQ_W*EW-1:0] wr_data;
  logic [DEQ_W*IW-1:0] rd_idx;
  logic [DEQ_W*EW-1:0] rd_data;

  // Readiness comes only from the registered count, so deq_ready never
  // reaches enq_ready combinationally.
  always_comb begin
    enq_ready = (DEPTH_P - count) >= ENQ_P;
    enq_fire  = (|enq_valid) && enq_ready;
    n_enq     = enq_fire ? PW'(popcnt(32'(enq_valid))) : '0;
    wr_en     = '0;
    wr_idx    = '0;
    wr_data   = '0;
    for (int unsigned i = 0; i < ENQ_W; i++) begin
      wr_en[i]              = enq_fire && enq_valid[i];
      wr_idx[i*IW +: IW]    = tail[IW-1:0] + IW'(i);
      wr_data[i*EW +: EW]   = {enq_data[i*DATA_W +: DATA_W], enq_excp[i*EXCP_W +: EXCP_W]};
    end
  end

  fq_regfile #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .WR_P  (ENQ_W),
    .RD_P  (DEQ_W),
    .IW    (IW)
  ) u_regfile (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // An exception entry blocks every lane above it and may itself only
  // issue on lane 0; firing is an in-order prefix of ready, valid lanes.
  always_comb begin
    logic blocked;
    logic prefix;
    logic ev;
    blocked   = 1'b0;
    prefix    = 1'b1;
    ev        = 1'b0;
    n_deq     = '0;
    deq_valid = '0;
    deq_data  = '0;
    deq_excp  = '0;
    rd_idx    = '0;
    for (int unsigned i = 0; i < DEQ_W; i++) begin
      rd_idx[i*IW +: IW]          = head[IW-1:0] + IW'(i);
      deq_data[i*DATA_W +: DATA_W] = rd_data[i*EW + EXCP_W +: DATA_W];
      deq_excp[i*EXCP_W +: EXCP_W] = rd_data[i*EW +: EXCP_W];
      ev           = rd_data[i*EW];
      deq_valid[i] = (count > PW'(i)) && !blocked && !((i > 0) && ev);
      if (prefix && deq_valid[i] && deq_ready[i]) n_deq = n_deq + PW'(1);
      else                                        prefix = 1'b0;
      if (ev) blocked = 1'b1;
    end
  end

  assign count_next = count + n_enq - n_deq;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      head        <= head + n_deq;
      tail        <= tail + n_enq;
      count       <= count_next;
      almost_full <= count_next >= AF_P;
    end
  end

  enq_valid_contiguous: assert property (@(posedge clk) disable iff (reset)
    ((enq_valid & (enq_valid + 1'b1)) == '0));

endmodule

// File: tb/tb_fetch_queue_mp.sv
// Directed bench for fetch_queue_mp with default parameters (depth 16, 2+2 lanes).
module tb_fetch_queue_mp;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [1:0]   enq_valid;
  logic [127:0] enq_data;
  logic [9:0]   enq_excp;
  logic         enq_ready;
  logic [1:0]   deq_valid;
  logic [127:0] deq_data;
  logic [9:0]   deq_excp;
  logic [1:0]   deq_ready;
  logic [4:0]   count;
  logic         almost_full;

  int checks = 0;
  int errors = 0;

  fetch_queue_mp #(
    .DATA_W    (64),
    .EXCP_W    (5),
    .DEPTH     (16),
    .ENQ_W     (2),
    .DEQ_W     (2),
    .AF_THRESH (12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .enq_valid   (enq_valid),
    .enq_data    (enq_data),
    .enq_excp    (enq_excp),
    .enq_ready   (enq_ready),
    .deq_valid   (deq_valid),
    .deq_data    (deq_data),
    .deq_excp    (deq_excp),
    .deq_ready   (deq_ready),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then return to idle inputs 1 ns after the edge.
  task automatic cyc(input logic [1:0] ev, input logic [63:0] d0, input logic [63:0] d1,
                     input logic [4:0] x0, input logic [4:0] x1,
                     input logic [1:0] dr, input logic fl);
    enq_valid = ev;
    enq_data  = {d1, d0};
    enq_excp  = {x1, x0};
    deq_ready = dr;
    flush     = fl;
    @(posedge clk);
    #1;
    enq_valid = 2'b00;
    enq_data  = '0;
    enq_excp  = '0;
    deq_ready = 2'b00;
    flush     = 1'b0;
  endtask

  function automatic logic [63:0] lane(input logic [127:0] v, input int i);
    return v[i*64 +: 64];
  endfunction

  initial begin
    excp_t ex;
    reset = 1'b1; flush = 1'b0; enq_valid = '0; enq_data = '0; enq_excp = '0; deq_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_count", 64'(count), 0);
    check("rst_deq_valid", 64'(deq_valid), 0);
    check("rst_enq_ready", 64'(enq_ready), 1);
    check("rst_af", 64'(almost_full), 0);

    // Two-lane enqueue, visible one cycle later
    cyc(2'b11, 64'hA, 64'hB, 5'd0, 5'd0, 2'b00, 1'b0);
    check("first_count", 64'(count), 2);
    check("first_deq_valid", 64'(deq_valid), 2'b11);
    check("first_lane0", lane(deq_data, 0), 64'hA);
    check("first_lane1", lane(deq_data, 1), 64'hB);

    // Fill from empty; almost_full from count 12, enq_ready drops at 16
    cyc(2'b00, 0, 0, 0, 0, 2'b00, 1'b1);
    check("flush_empty", 64'(count), 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(2'b11, 64'(100 + 2*(k-1)), 64'(101 + 2*(k-1)), 0, 0, 2'b00, 1'b0);
      check("fill_count", 64'(count), 64'(2*k));
      check("fill_af", 64'(almost_full), (2*k >= 12) ? 64'd1 : 64'd0);
      check("fill_ready", 64'(enq_ready), (2*k <= 14) ? 64'd1 : 64'd0);
    end
    cyc(2'b11, 64'd900, 64'd901, 0, 0, 2'b00, 1'b0);
    check("full_ignored_count", 64'(count), 16);
    check("full_lane0", lane(deq_data, 0), 100);

    // Drain two per cycle
    for (int k = 1; k <= 8; k++) begin
      cyc(2'b00, 0, 0, 0, 0, 2'b11, 1'b0);
      check("drain_count", 64'(count), 64'(16 - 2*k));
      if (k < 8) check("drain_lane0", lane(deq_data, 0), 64'(100 + 2*k));
    end
    check("drain_deq_valid", 64'(deq_valid), 0);

    // Steady traffic to move head/tail (both at 16) so tail reaches index 15
    for (int k = 0; k < 7; k++) cyc(2'b11, 64'(200 + 2*k), 64'(201 + 2*k), 0, 0, 2'b11, 1'b0);
    check("steady_count", 64'(count), 2);
    check("steady_lane0", lane(deq_data, 0), 212);
    cyc(2'b01, 64'd214, 0, 0, 0, 2'b11, 1'b0);
    check("steady_count1", 64'(count), 1);
    check("steady_lane0b", lane(deq_data, 0), 214);
    cyc(2'b00, 0, 0, 0, 0, 2'b01, 1'b0);
    check("pre_wrap_count", 64'(count), 0);

    // Wrap: C lands at index 15, D at index 0
    cyc(2'b11, 64'hC, 64'hD, 0, 0, 2'b00, 1'b0);
    check("wrap_count", 64'(count), 2);
    check("wrap_lane0", lane(deq_data, 0), 64'hC);
    check("wrap_lane1", lane(deq_data, 1), 64'hD);
    cyc(2'b00, 0, 0, 0, 0, 2'b01, 1'b0);
    check("wrap_after_lane0", lane(deq_data, 0), 64'hD);
    check("wrap_after_count", 64'(count), 1);
    cyc(2'b00, 0, 0, 0, 0, 2'b01, 1'b0);
    check("wrap_empty", 64'(count), 0);

    // Exception on the head entry issues alone
    ex.num = 4'd3; ex.valid = 1'b1;
    cyc(2'b11, 64'hE0, 64'hE1, ex, 5'd0, 2'b00, 1'b0);
    check("excp_count2", 64'(count), 2);
    check("excp_valid_lane0_only", 64'(deq_valid), 2'b01);
    check("excp_field", 64'(deq_excp[4:0]), 5'b00111);
    cyc(2'b00, 0, 0, 0, 0, 2'b11, 1'b0);
    check("excp_count1", 64'(count), 1);
    check("excp_next_lane0", lane(deq_data, 0), 64'hE1);
    check("excp_next_valid", 64'(deq_valid), 2'b01);
    cyc(2'b00, 0, 0, 0, 0, 2'b11, 1'b0);
    check("excp_count0", 64'(count), 0);

    // Exception in the second entry holds back lane 1
    cyc(2'b11, 64'hF0, 64'hF1, 5'd0, 5'b00011, 2'b00, 1'b0);
    check("excp1_valid", 64'(deq_valid), 2'b01);
    cyc(2'b00, 0, 0, 0, 0, 2'b11, 1'b0);
    check("excp1_count", 64'(count), 1);
    check("excp1_lane0", lane(deq_data, 0), 64'hF1);
    check("excp1_field", 64'(deq_excp[4:0]), 5'b00011);
    cyc(2'b00, 0, 0, 0, 0, 2'b01, 1'b0);
    check("excp1_drained", 64'(count), 0);

    // Flush beats simultaneous enqueue and dequeue
    for (int k = 0; k < 3; k++) cyc(2'b11, 64'(300 + 2*k), 64'(301 + 2*k), 0, 0, 2'b00, 1'b0);
    check("preflush_count", 64'(count), 6);
    cyc(2'b11, 64'd400, 64'd401, 0, 0, 2'b11, 1'b1);
    check("flush_count", 64'(count), 0);
    check("flush_deq_valid", 64'(deq_valid), 0);
    check("flush_enq_ready", 64'(enq_ready), 1);
    check("flush_af", 64'(almost_full), 0);

    // Partial dequeue and the in-order prefix rule
    cyc(2'b11, 64'h50, 64'h51, 0, 0, 2'b00, 1'b0);
    cyc(2'b01, 64'h52, 0, 0, 0, 2'b00, 1'b0);
    check("part_count3", 64'(count), 3);
    cyc(2'b00, 0, 0, 0, 0, 2'b01, 1'b0);
    check("part_count2", 64'(count), 2);
    check("part_lane0", lane(deq_data, 0), 64'h51);
    check("part_lane1", lane(deq_data, 1), 64'h52);
    cyc(2'b00, 0, 0, 0, 0, 2'b10, 1'b0);
    check("prefix_count", 64'(count), 2);
    check("prefix_lane0", lane(deq_data, 0), 64'h51);
    check("prefix_valid", 64'(deq_valid), 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
